// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the C2H DMA frame packer: default geometry of the
// input word stream and packed frame, the packer state encoding and the
// widths of the status counters exposed on the packer ports.
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int DMA_IN_W    = 32;
    localparam int DMA_FRAME_W = 4064;
    localparam int DMA_WORDS   = DMA_FRAME_W / DMA_IN_W;

    // fill_level must be able to show WORDS itself while a full frame waits.
    localparam int FILL_W      = 7;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OFFER = 2'd2
    } state_e;

endpackage

// File: rtl/dma_flush_timer.sv
// ---------------------------------------------------------------------------
// dma_flush_timer
// Counts consecutive idle cycles of a partially filled frame and raises a
// one-cycle flush request on the FLUSH_CYCLES-th consecutive idle cycle.
// Only instantiated when FRAME_FLUSH_EN is defined.
//
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  synchronous clear
//   idle   in  1  partial frame present and no word accepted this cycle
//   flush  out 1  pad out the partial frame this cycle
// ---------------------------------------------------------------------------
module dma_flush_timer #(
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic idle,
    output logic flush
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The request fires while the counter already holds the number of idle
    // cycles seen before this one, so the flush lands on the idle cycle that
    // completes the window.
    assign flush = idle && !clr && (cnt_q == LAST_CNT);

    // Next idle count: any accept (idle low) or clear restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !idle) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_frame_packer.sv
// ---------------------------------------------------------------------------
// dma_frame_packer
// Packs WORDS consecutive IN_W-bit words from a valid/ready stream into one
// FRAME_W-bit frame and offers it to the 512-bit AXI-stream serializer over
// the data / data_valid / data_next interface. A single frame buffer is used,
// so input is back-pressured from the moment the frame is full until the
// serializer has latched it.
//
// Optional feature (macro FRAME_FLUSH_EN): a partial frame that sees
// FLUSH_CYCLES idle cycles is padded with PAD_WORD and offered as if full.
//
// Ports:
//   m_axis_c2h_aclk     in  1        clock
//   m_axis_c2h_aresetn  in  1        asynchronous active-low reset
//   clr                 in  1        synchronous clear (same effect as reset)
//   in_data             in  IN_W     input word
//   in_valid            in  1        input word valid
//   in_ready            out 1        word accepted this cycle when valid
//   data                out FRAME_W  frame; word k at data[k*IN_W +: IN_W]
//   data_valid          out 1        frame offered
//   data_next           in  1        serializer idle (1) / busy (0)
//   fill_level          out 7        words held in current frame
//   frame_cnt           out 16       frames handed off (wrapping)
// ---------------------------------------------------------------------------
module dma_frame_packer
    import dma_pkg::*;
#(
    parameter int              IN_W         = DMA_IN_W,
    parameter int              FRAME_W      = DMA_FRAME_W,
    parameter logic [IN_W-1:0] PAD_WORD     = {IN_W{1'b0}},
    parameter int              FLUSH_CYCLES = 1024
) (
    input  logic                   m_axis_c2h_aclk,
    input  logic                   m_axis_c2h_aresetn,
    input  logic                   clr,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FRAME_W-1:0]     data,
    output logic                   data_valid,
    input  logic                   data_next,
    output logic [FILL_W-1:0]      fill_level,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int WORDS = FRAME_W / IN_W;
    localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(WORDS - 1);

    if ((FRAME_W % IN_W) != 0) begin : g_bad_ratio
        $error("dma_frame_packer: FRAME_W must be an integer multiple of IN_W");
    end
    if ((WORDS < 1) || (WORDS > 127)) begin : g_bad_words
        $error("dma_frame_packer: WORDS must lie in 1..127 to fit fill_level");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("dma_frame_packer: FLUSH_CYCLES must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [FRAME_W-1:0]     data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic accept_s;
    logic flush_s;

    assign in_ready   = (state_q == ST_FILL);
    assign accept_s   = in_valid && (state_q == ST_FILL);
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign fill_level = fill_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef FRAME_FLUSH_EN
    logic idle_s;

    // In FILL an accept happens exactly when in_valid is high.
    assign idle_s = (state_q == ST_FILL) && (fill_q != {FILL_W{1'b0}}) && !in_valid;

    dma_flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk   (m_axis_c2h_aclk),
        .rst_n (m_axis_c2h_aresetn),
        .clr   (clr),
        .idle  (idle_s),
        .flush (flush_s)
    );
`else
    assign flush_s = 1'b0;
`endif

    // Next-state logic for the fill / wait / offer sequence and buffer writes.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        frame_cnt_d  = frame_cnt_q;
        if (clr) begin
            state_d      = ST_FILL;
            fill_d       = {FILL_W{1'b0}};
            data_d       = {FRAME_W{1'b0}};
            data_valid_d = 1'b0;
            frame_cnt_d  = {FRAME_CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept_s) begin
                        for (int k = 0; k < WORDS; k++) begin
                            data_d[k*IN_W +: IN_W] = (FILL_W'(k) == fill_q) ?
                                                     in_data : data_q[k*IN_W +: IN_W];
                        end
                        fill_d = fill_q + FILL_W'(1);
                        // OFFER only while the serializer is idle, so the next
                        // low data_next really is this frame being latched.
                        if (fill_q == LAST_IDX) begin
                            state_d      = data_next ? ST_OFFER : ST_WAIT;
                            data_valid_d = data_next;
                        end else begin
                            state_d      = ST_FILL;
                            data_valid_d = 1'b0;
                        end
                    end else if (flush_s) begin
                        // Pad the unwritten tail; fill_level keeps the real count.
                        for (int k = 0; k < WORDS; k++) begin
                            data_d[k*IN_W +: IN_W] = (FILL_W'(k) >= fill_q) ?
                                                     PAD_WORD : data_q[k*IN_W +: IN_W];
                        end
                        state_d      = data_next ? ST_OFFER : ST_WAIT;
                        data_valid_d = data_next;
                    end else begin
                        state_d      = ST_FILL;
                        data_valid_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (data_next) begin
                        state_d      = ST_OFFER;
                        data_valid_d = 1'b1;
                    end else begin
                        state_d      = ST_WAIT;
                        data_valid_d = 1'b0;
                    end
                end
                ST_OFFER: begin
                    // A low data_next here means the serializer took the frame.
                    if (!data_next) begin
                        state_d      = ST_FILL;
                        data_valid_d = 1'b0;
                        fill_d       = {FILL_W{1'b0}};
                        frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                    end else begin
                        state_d      = ST_OFFER;
                        data_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d      = ST_FILL;
                    fill_d       = {FILL_W{1'b0}};
                    data_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, frame buffer and status registers.
    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            state_q      <= ST_FILL;
            fill_q       <= {FILL_W{1'b0}};
            data_q       <= {FRAME_W{1'b0}};
            data_valid_q <= 1'b0;
            frame_cnt_q  <= {FRAME_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule
